// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car/call subsystem: floor encoding,
// travel direction and the door sequencing states.
package elevator_pkg;

  localparam int NFLOORS = 4;

  localparam logic [1:0] FLOOR_A = 2'd0;
  localparam logic [1:0] FLOOR_B = 2'd1;
  localparam logic [1:0] FLOOR_C = 2'd2;
  localparam logic [1:0] FLOOR_D = 2'd3;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef enum logic [1:0] {
    DOOR_IDLE  = 2'd0,
    DOOR_OPEN  = 2'd1,
    DOOR_CLOSE = 2'd2
  } door_state_e;

  function automatic logic [2:0] popcount_floors(input logic [NFLOORS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button bit: 2-flop synchronizer followed by a stable-count debouncer.
// rise_o pulses for one cycle when the debounced level goes high.
module btn_debounce
  import elevator_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic          meta_q;
  logic          sync_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only advances while the synced value disagrees with the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync_q;
        rise_d  = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/elevator_call_panel.sv
// Call front end: debounced buttons latch pending calls, and a door FSM holds
// the car at a called floor for dwell/close before clearing that call.
//
// state  | meaning
// IDLE   | car free to move; call_req mirrors pending
// OPEN   | door open at cf_q, dwell counting; car held
// CLOSE  | door closing; car held, press at cf_q re-opens
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int DEB_CYCLES   = 16,
  parameter int DWELL_CYCLES = 100,
  parameter int CLOSE_CYCLES = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NFLOORS-1:0] btn_raw,
  input  logic [1:0]         car_floor,
  output logic [NFLOORS-1:0] call_req,
  output logic [NFLOORS-1:0] pending,
  output logic               door_open,
  output logic               car_hold,
  output logic               served,
  output logic [1:0]         served_floor,
  output logic [2:0]         pending_count,
  output logic               fault
);

  localparam int DW = $clog2(DWELL_CYCLES) + 1;
  localparam int CW = $clog2(CLOSE_CYCLES) + 1;

  localparam logic [1:0] S_IDLE  = DOOR_IDLE;
  localparam logic [1:0] S_OPEN  = DOOR_OPEN;
  localparam logic [1:0] S_CLOSE = DOOR_CLOSE;

  logic [NFLOORS-1:0] rise;
  logic [NFLOORS-1:0] pending_q, pending_d;
  logic [1:0]         state_q, state_d;
  logic [1:0]         cf_q;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [CW-1:0]      close_q, close_d;
  logic               served_q, served_d;
  logic [1:0]         served_floor_q, served_floor_d;
  logic               fault_q, fault_d;
  logic               hold;

  for (genvar i = 0; i < NFLOORS; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock (clock),
      .reset (reset),
      .btn_i (btn_raw[i]),
      .rise_o(rise[i])
    );
  end

  assign hold = (state_q != S_IDLE);

  always_comb begin
    state_d        = state_q;
    dwell_d        = dwell_q;
    close_d        = close_q;
    pending_d      = pending_q | rise;
    served_d       = 1'b0;
    served_floor_d = served_floor_q;
    fault_d        = fault_q;

    // The car moving while held is a controller fault: drop the door sequence
    // without serving anything.
    if (hold && (car_floor != cf_q)) begin
      fault_d = 1'b1;
      state_d = S_IDLE;
      dwell_d = '0;
      close_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pending_q[cf_q]) begin
            state_d = S_OPEN;
            dwell_d = '0;
          end
        end
        S_OPEN: begin
          if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
            // A press at cf_q on this edge is absorbed by the serve.
            pending_d[cf_q] = 1'b0;
            served_d        = 1'b1;
            served_floor_d  = cf_q;
            state_d         = S_CLOSE;
            dwell_d         = '0;
            close_d         = '0;
          end else if (rise[cf_q]) begin
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        S_CLOSE: begin
          if (rise[cf_q]) begin
            state_d = S_OPEN;
            dwell_d = '0;
            close_d = '0;
          end else if (close_q == CW'(CLOSE_CYCLES - 1)) begin
            state_d = S_IDLE;
            close_d = '0;
          end else begin
            close_d = close_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          dwell_d = '0;
          close_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cf_q           <= '0;
      pending_q      <= '0;
      dwell_q        <= '0;
      close_q        <= '0;
      served_q       <= 1'b0;
      served_floor_q <= '0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cf_q           <= car_floor;
      pending_q      <= pending_d;
      dwell_q        <= dwell_d;
      close_q        <= close_d;
      served_q       <= served_d;
      served_floor_q <= served_floor_d;
      fault_q        <= fault_d;
    end
  end

  assign call_req      = (state_q == S_IDLE) ? pending_q : '0;
  assign pending       = pending_q;
  assign door_open     = (state_q == S_OPEN);
  assign car_hold      = hold;
  assign served        = served_q;
  assign served_floor  = served_floor_q;
  assign pending_count = popcount_floors(pending_q);
  assign fault         = fault_q;

endmodule
